// File: rtl/fp_sweep_gen.sv
// Fixed-point sweep generator: steps a signed accumulator from start to stop by step
// and presents each value as an exact IEEE-754 single on a valid/ready output.
module fp_sweep_gen #(
    parameter int unsigned INT_W  = 8,
    parameter int unsigned FRAC_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [INT_W+FRAC_W-1:0]   cfg_start,
    input  logic [INT_W+FRAC_W-1:0]   cfg_stop,
    input  logic [INT_W+FRAC_W-1:0]   cfg_step,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [31:0]               x_out,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int unsigned W = INT_W + FRAC_W;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state, state_n;
    logic [W-1:0]   acc, acc_n;
    logic [W-1:0]   start_q, start_n, stop_q, stop_n, step_q, step_n;
    logic           mode_q, mode_n;
    logic           valid_n, busy_n, done_n, err_n;
    logic [31:0]    x_n;
    logic           cfg_ok, xfer, nxt_le;
    logic [W:0]     nxt;

    // Exact fixed-point to single conversion; W <= 24 keeps every value representable.
    function automatic logic [31:0] fp(input logic [W-1:0] v);
        logic [W-1:0] mag;
        logic [23:0]  m;
        logic [7:0]   e;
        int           p;
        if (v == '0) return 32'h0;
        mag = v[W-1] ? W'(-v) : v;
        p = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (mag[i]) p = i;
        end
        e = 8'(127 + p - int'(FRAC_W));
        m = 24'(mag) << (23 - p);
        return {v[W-1], e, m[22:0]};
    endfunction

    assign cfg_ok = (cfg_step != '0) && ($signed(cfg_start) <= $signed(cfg_stop));
    assign xfer   = out_valid && out_ready;
    // One extra bit so an overflowing step still compares above stop.
    assign nxt    = {acc[W-1], acc} + {1'b0, step_q};
    assign nxt_le = $signed(nxt) <= $signed({stop_q[W-1], stop_q});

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            x_out     <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            start_q   <= start_n;
            stop_q    <= stop_n;
            step_q    <= step_n;
            mode_q    <= mode_n;
            out_valid <= valid_n;
            x_out     <= x_n;
            busy      <= busy_n;
            done      <= done_n;
            cfg_err   <= err_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && cfg_ok) state_n = RUN;
            RUN:     if (xfer && !nxt_le && !mode_q) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of outputs and datapath
    always_comb begin
        acc_n   = acc;
        start_n = start_q;
        stop_n  = stop_q;
        step_n  = step_q;
        mode_n  = mode_q;
        valid_n = out_valid;
        x_n     = x_out;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        start_n = cfg_start;
                        stop_n  = cfg_stop;
                        step_n  = cfg_step;
                        mode_n  = mode;
                        acc_n   = cfg_start;
                        x_n     = fp(cfg_start);
                        valid_n = 1'b1;
                        busy_n  = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    if (nxt_le) begin
                        acc_n = nxt[W-1:0];
                        x_n   = fp(nxt[W-1:0]);
                    end else if (mode_q) begin
                        acc_n = start_q;
                        x_n   = fp(start_q);
                    end else begin
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_sweep_gen.sv
// Scoreboard bench for fp_sweep_gen: stimulus pushes expected samples, a negedge monitor checks transfers.
module tb_fp_sweep_gen;

    logic        clk = 1'b0;
    logic        rst, start, mode, out_ready;
    logic [23:0] cfg_start, cfg_stop, cfg_step;
    logic        out_valid, busy, done, cfg_err;
    logic [31:0] x_out;

    fp_sweep_gen #(.INT_W(8), .FRAC_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .out_ready(out_ready), .out_valid(out_valid), .x_out(x_out),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] ref_q[$];
    int          tests = 0, fails = 0;
    int          done_cnt = 0;
    logic        bp_en = 1'b0;
    int          bp_cnt = 0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_x = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Exact single-precision bits of a real that is representable as a single
    function automatic logic [31:0] sp(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Ready pattern 1,0,0 repeating under backpressure, else always ready
    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? (bp_cnt % 3 == 0) : 1'b1;
        bp_cnt++;
    end

    // Monitor: stability under stall, scoreboard compare on transfer, pulse counting
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", x_out, hold_x);
            end
            hold_pend = out_valid && !out_ready;
            hold_x    = x_out;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_sample: got %08h expected none", x_out);
                end else begin
                    check("sample", x_out, exp_q.pop_front());
                end
                rx_q.push_back(x_out);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ramp(input real s, input real st, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(sp(s + real'(i) * st));
    endtask

    task automatic do_start(input logic m, input logic [23:0] s, input logic [23:0] e,
                            input logic [23:0] st);
        mode = m; cfg_start = s; cfg_stop = e; cfg_step = st;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, n, diff;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_x", x_out, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        tick();

        // 1: full one-shot sweep -5.0 .. 5.0 by 0.25
        rx_q.delete();
        push_ramp(-5.0, 0.25, 41);
        base = done_cnt;
        do_start(1'b0, 24'hFB0000, 24'h050000, 24'h004000);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1_done", base, 200);
        tick(); tick();
        check("t1_count", 32'(rx_q.size()), 32'd41);
        if (rx_q.size() == 41) begin
            check("t1_s1", rx_q[0], 32'hC0A00000);
            check("t1_s2", rx_q[1], 32'hC0980000);
            check("t1_s21", rx_q[20], 32'h00000000);
            check("t1_s41", rx_q[40], 32'h40A00000);
        end
        check("t1_valid_after", 32'(out_valid), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_done_once", 32'(done_cnt - base), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        ref_q = rx_q;

        // 2: same sweep under backpressure
        bp_en = 1'b1;
        rx_q.delete();
        push_ramp(-5.0, 0.25, 41);
        base = done_cnt;
        do_start(1'b0, 24'hFB0000, 24'h050000, 24'h004000);
        wait_done("t2_done", base, 400);
        tick();
        bp_en = 1'b0;
        check("t2_count", 32'(rx_q.size()), 32'd41);
        diff = 0;
        for (int i = 0; i < rx_q.size() && i < ref_q.size(); i++)
            if (rx_q[i] !== ref_q[i]) diff++;
        check("t2_sequence", 32'(diff), 32'd0);

        // 3: continuous wrap 0, 0.5, 1.0, 0, ...
        rx_q.delete();
        for (int i = 0; i < 24; i++)
            exp_q.push_back((i % 3 == 0) ? 32'h00000000 :
                            (i % 3 == 1) ? 32'h3F000000 : 32'h3F800000);
        base = done_cnt;
        do_start(1'b1, 24'h000000, 24'h010000, 24'h008000);
        n = 0;
        while (exp_q.size() > 4 && n < 200) begin
            tick();
            n++;
        end
        check("t3_progress", 32'(exp_q.size() <= 4), 32'd1);
        check("t3_no_done", 32'(done_cnt - base), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        tick();

        // 4: stop not reachable exactly
        rx_q.delete();
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h3EC00000);
        exp_q.push_back(32'h3F400000);
        base = done_cnt;
        do_start(1'b0, 24'h000000, 24'h010000, 24'h006000);
        wait_done("t4_done", base, 50);
        tick();
        check("t4_count", 32'(rx_q.size()), 32'd3);

        // 5: extremes, overflow caught by wide compare
        rx_q.delete();
        exp_q.push_back(32'hC3000000);
        exp_q.push_back(32'hB7800000);
        exp_q.push_back(32'h42FFFFFC);
        base = done_cnt;
        do_start(1'b0, 24'h800000, 24'h7FFFFF, 24'h7FFFFF);
        wait_done("t5_done", base, 50);
        tick();
        check("t5_count", 32'(rx_q.size()), 32'd3);

        // 6a: rejected configurations
        do_start(1'b0, 24'h000000, 24'h010000, 24'h000000);
        check("t6_step0_err", 32'(cfg_err), 32'd1);
        check("t6_step0_busy", 32'(busy), 32'd0);
        check("t6_step0_valid", 32'(out_valid), 32'd0);
        tick();
        check("t6_err_pulse_end", 32'(cfg_err), 32'd0);
        do_start(1'b0, 24'h020000, 24'h010000, 24'h001000);
        check("t6_order_err", 32'(cfg_err), 32'd1);
        check("t6_order_busy", 32'(busy), 32'd0);
        tick();

        // 6b: start during RUN is ignored
        rx_q.delete();
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h3EC00000);
        exp_q.push_back(32'h3F400000);
        base = done_cnt;
        do_start(1'b0, 24'h000000, 24'h010000, 24'h006000);
        do_start(1'b1, 24'h020000, 24'h040000, 24'h010000);
        wait_done("t6b_done", base, 50);
        tick(); tick();
        check("t6b_count", 32'(rx_q.size()), 32'd3);
        check("t6b_idle", 32'(busy), 32'd0);

        // 6c: reset during sample 5 aborts, then a fresh start restarts
        rx_q.delete();
        push_ramp(-5.0, 0.25, 41);
        base = done_cnt;
        do_start(1'b0, 24'hFB0000, 24'h050000, 24'h004000);
        n = 0;
        while (rx_q.size() < 4 && n < 100) begin
            tick();
            n++;
        end
        check("t6c_reached_s5", 32'(rx_q.size()), 32'd4);
        rst = 1'b1;
        tick();
        check("t6c_rst_valid", 32'(out_valid), 32'd0);
        check("t6c_rst_x", x_out, 32'h0);
        check("t6c_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check("t6c_no_done", 32'(done_cnt - base), 32'd0);
        rx_q.delete();
        push_ramp(-5.0, 0.25, 41);
        base = done_cnt;
        do_start(1'b0, 24'hFB0000, 24'h050000, 24'h004000);
        wait_done("t6c_done", base, 200);
        tick();
        check("t6c_count", 32'(rx_q.size()), 32'd41);
        if (rx_q.size() > 0) check("t6c_first", rx_q[0], 32'hC0A00000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_sweep_gen.md
Name: fp_sweep_gen

Overview:
- Stimulus source that sits directly upstream of the waveform evaluators (sawtooth and similar). Its IEEE-754 single output feeds their 32-bit x input.
- Steps a signed fixed-point accumulator from a configured start value to a stop value by a fixed increment.
- Converts each accumulator value exactly to IEEE-754 single precision and presents it on a valid/ready output.
- Supports one-shot sweeps (ends with a done pulse) and continuous wrap-around sweeps.

Parameters:
- INT_W, 8, integer bits of the signed fixed-point format, sign bit included.
- FRAC_W, 16, fractional bits. Accumulator width W = INT_W+FRAC_W = 24. W must be ≤ 24 so that every conversion is exact.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- mode  in  1  0 = one-shot, 1 = continuous wrap; latched at start.
- cfg_start  in  W  signed two's-complement first value; latched at start.
- cfg_stop  in  W  signed inclusive upper bound; latched at start.
- cfg_step  in  W  unsigned increment, must be nonzero; latched at start.
- out_ready  in  1  downstream accepts x_out this cycle.
- out_valid  out  1  x_out holds a valid sample.
- x_out  out  32  IEEE-754 single value of the current accumulator.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a one-shot sweep completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: state IDLE; out_valid=0, x_out=32'h0, busy=0, done=0, cfg_err=0; accumulator cleared. A reset asserted mid-sweep aborts the sweep with no done pulse.
- FSM states: IDLE, RUN, FIN.
  - IDLE, start=1, cfg_step≠0, cfg_start≤cfg_stop (signed compare):
    - latch the configuration;
    - acc←cfg_start, x_out←fp(cfg_start), out_valid←1, busy←1;
    - go to RUN.
  - IDLE, start=1, with cfg_step=0 or cfg_start>cfg_stop: stay in IDLE and pulse cfg_err for 1 cycle.
  - start while in RUN or FIN is ignored. cfg_* changes during a sweep have no effect.
- Latency: start sampled at edge N gives out_valid=1 with the first sample after edge N.
- Handshake: x_out and out_valid hold stable while out_valid && !out_ready. Each sample is transferred exactly once; no skips, no repeats.
- On transfer (out_valid && out_ready) in RUN:
  - nxt = acc + step, computed at W+1 bits so overflow is never lost;
  - if nxt ≤ stop (signed, W+1 bits): acc←nxt, x_out←fp(nxt), out_valid stays 1;
  - else, mode=1: acc←start, x_out←fp(start) (wrap);
  - else, mode=0: out_valid←0, busy←0, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. The stop value itself is emitted only if it is reachable exactly.
- Conversion fp(v):
  - v=0 gives 32'h00000000 (positive zero only).
  - Otherwise sign = v[W-1] and mag = |v| as W-bit unsigned (the most-negative value maps to 2^(W-1)).
  - p = index of the leading one of mag.
  - exponent = 127 + p − FRAC_W.
  - mantissa = (mag << (23−p))[22:0].
  - No rounding: the result is exact by construction.
- Timing: x_out is registered. The conversion is combinational from the accumulator/adder into that register, so there is one output register stage and no additional pipeline.

Test Plan:
1. Full sweep. mode=0, cfg_start=24'hFB0000 (−5.0), cfg_stop=24'h050000 (5.0), cfg_step=24'h004000 (0.25), out_ready=1. Require:
   - exactly 41 samples;
   - sample 1 = 32'hC0A00000, sample 2 = 32'hC0980000, sample 21 = 32'h00000000, sample 41 = 32'h40A00000;
   - then one done pulse; out_valid=0 afterwards.
2. Backpressure. Repeat test 1 with out_ready toggling 1,0,0,1,… Require x_out stable whenever valid && !ready, and a received sequence identical to test 1.
3. Wrap. mode=1, start=0, stop=24'h010000, step=24'h008000. Require 00000000, 3F000000, 3F800000, 00000000, 3F000000, … with no done pulse over 20 transfers.
4. Non-aligned stop. start=0, stop=24'h010000, step=24'h006000. Require 00000000, 3EC00000, 3F400000, then done (1.125 is not emitted).
5. Extremes. start=24'h800000, stop=24'h7FFFFF, step=24'h7FFFFF. Require 32'hC3000000, 32'hB7800000, 32'h42FFFFFC, then done (the 25-bit compare catches the overflow).
6. Control corners.
   - cfg_step=0 at start: cfg_err pulse, busy stays 0.
   - start pulsed during RUN: ignored.
   - rst raised during sample 5 of test 1: next cycle out_valid=0, x_out=0, no done pulse; a fresh start then restarts from sample 1.
